// File: rtl/rx_ts_qualifier_if.sv
// Bus bundle for the training-sequence qualifier.
// The master side drives ordered sets and configuration; the slave side is the qualifier.
interface rx_ts_qualifier_if #(
  parameter int LANES = 16,
  parameter int OS_W  = 128,
  parameter int CNT_W = 5,
  parameter int TMR_W = 24
);
  logic                    start;
  logic                    validOrderedSets;
  logic [LANES*OS_W-1:0]   orderedSets;
  logic [LANES-1:0]        laneActive;
  logic                    expectTS2;
  logic                    linkCheckEn;
  logic [7:0]              expectLink;
  logic                    laneCheckEn;
  logic [CNT_W-1:0]        threshold;
  logic                    requireAll;
  logic [TMR_W-1:0]        timeoutCycles;
  logic                    busy;
  logic                    finish;
  logic                    timedOut;
  logic [LANES-1:0]        qualifiedLanes;
  logic [7:0]              rateId;
  logic [7:0]              linkNumberOut;

  modport master (
    output start, validOrderedSets, orderedSets, laneActive, expectTS2,
           linkCheckEn, expectLink, laneCheckEn, threshold, requireAll, timeoutCycles,
    input  busy, finish, timedOut, qualifiedLanes, rateId, linkNumberOut
  );

  modport slave (
    input  start, validOrderedSets, orderedSets, laneActive, expectTS2,
           linkCheckEn, expectLink, laneCheckEn, threshold, requireAll, timeoutCycles,
    output busy, finish, timedOut, qualifiedLanes, rateId, linkNumberOut
  );
endinterface

// File: rtl/rx_ts_qualifier.sv
// Counts consecutive identical TS1/TS2 ordered sets per lane and reports
// completion (with the rate id / link number of the lowest qualified lane) or timeout.
module rx_ts_qualifier #(
  parameter int LANES = 16,
  parameter int OS_W  = 128,
  parameter int CNT_W = 5,
  parameter int TMR_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  rx_ts_qualifier_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2,
    TOUT  = 2'd3
  } state_t;

  localparam logic [7:0]       TS1_ID   = 8'h4A;
  localparam logic [7:0]       TS2_ID   = 8'h45;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q  [LANES];
  logic [CNT_W-1:0] cnt_d  [LANES];
  logic [39:0]      copy_q [LANES];
  logic [39:0]      copy_d [LANES];
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_en_q, tmr_en_d;
  logic [LANES-1:0] qual_q, qual_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             tout_q, tout_d;
  logic [7:0]       rate_q, rate_d;
  logic [7:0]       link_q, link_d;

  logic [7:0]       id_s;
  logic [39:0]      sym_s      [LANES];
  logic [LANES-1:0] match_s;
  logic [CNT_W-1:0] thr_s;
  logic [CNT_W-1:0] cnt_upd_s  [LANES];
  logic [39:0]      copy_upd_s [LANES];
  logic [LANES-1:0] qual_upd_s;
  logic             comp_s;
  logic [7:0]       sel_rate_s;
  logic [7:0]       sel_link_s;

  // sym_s holds symbols 1..5 of each lane; symbol 6 carries the TS identifier.
  always_comb begin
    id_s    = bus.expectTS2 ? TS2_ID : TS1_ID;
    match_s = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sym_s[i]   = bus.orderedSets[i*OS_W+8 +: 40];
      match_s[i] = bus.validOrderedSets && bus.laneActive[i] &&
                   (bus.orderedSets[i*OS_W+48 +: 8] == id_s) &&
                   (!bus.linkCheckEn || (sym_s[i][7:0] == bus.expectLink)) &&
                   (!bus.laneCheckEn || (sym_s[i][15:8] == 8'(i)));
    end
  end

  // A zero count doubles as "first match after clear", so it always reloads the copy.
  always_comb begin
    thr_s      = (bus.threshold == CNT_ZERO) ? CNT_ONE : bus.threshold;
    qual_upd_s = {LANES{1'b0}};
    sel_rate_s = 8'd0;
    sel_link_s = 8'd0;
    for (int i = 0; i < LANES; i++) begin
      cnt_upd_s[i]  = cnt_q[i];
      copy_upd_s[i] = copy_q[i];
      if (!bus.laneActive[i]) begin
        cnt_upd_s[i] = CNT_ZERO;
      end else if (!bus.validOrderedSets) begin
        cnt_upd_s[i] = cnt_q[i];
      end else if (!match_s[i]) begin
        cnt_upd_s[i] = CNT_ZERO;
      end else if ((cnt_q[i] != CNT_ZERO) && (sym_s[i] == copy_q[i])) begin
        cnt_upd_s[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX : (cnt_q[i] + CNT_ONE);
      end else begin
        cnt_upd_s[i]  = CNT_ONE;
        copy_upd_s[i] = sym_s[i];
      end
      qual_upd_s[i] = (cnt_upd_s[i] >= thr_s) && bus.laneActive[i];
    end
    if (bus.requireAll) begin
      comp_s = (bus.laneActive != {LANES{1'b0}}) &&
               ((qual_upd_s & bus.laneActive) == bus.laneActive);
    end else begin
      comp_s = (qual_upd_s != {LANES{1'b0}});
    end
    // Walk downwards so the lowest qualified lane is the last one written.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (qual_upd_s[i]) begin
        sel_rate_s = copy_upd_s[i][31:24];
        sel_link_s = copy_upd_s[i][7:0];
      end else begin
        sel_rate_s = sel_rate_s;
        sel_link_s = sel_link_s;
      end
    end
  end

  // Next-state and registered-output computation; start has priority over completion.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    tmr_en_d = tmr_en_q;
    qual_d   = qual_q;
    rate_d   = rate_q;
    link_d   = link_q;
    finish_d = 1'b0;
    tout_d   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      cnt_d[i]  = cnt_q[i];
      copy_d[i] = copy_q[i];
    end
    if (bus.start && ((state_q == IDLE) || (state_q == COUNT))) begin
      state_d  = COUNT;
      tmr_d    = bus.timeoutCycles;
      tmr_en_d = (bus.timeoutCycles != TMR_ZERO);
      qual_d   = {LANES{1'b0}};
      rate_d   = 8'd0;
      link_d   = 8'd0;
      for (int i = 0; i < LANES; i++) begin
        cnt_d[i]  = CNT_ZERO;
        copy_d[i] = 40'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COUNT: begin
          for (int i = 0; i < LANES; i++) begin
            cnt_d[i]  = cnt_upd_s[i];
            copy_d[i] = copy_upd_s[i];
          end
          qual_d = qual_upd_s;
          if (tmr_en_q && (tmr_q != TMR_ZERO)) begin
            tmr_d = tmr_q - TMR_ONE;
          end else begin
            tmr_d = tmr_q;
          end
          if (comp_s) begin
            state_d  = DONE;
            finish_d = 1'b1;
            rate_d   = sel_rate_s;
            link_d   = sel_link_s;
          end else if (tmr_en_q && (tmr_q == TMR_ONE)) begin
            state_d = TOUT;
            tout_d  = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
        DONE:    state_d = IDLE;
        TOUT:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == COUNT);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tmr_q    <= TMR_ZERO;
      tmr_en_q <= 1'b0;
      qual_q   <= {LANES{1'b0}};
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      tout_q   <= 1'b0;
      rate_q   <= 8'd0;
      link_q   <= 8'd0;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i]  <= CNT_ZERO;
        copy_q[i] <= 40'd0;
      end
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      tmr_en_q <= tmr_en_d;
      qual_q   <= qual_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      tout_q   <= tout_d;
      rate_q   <= rate_d;
      link_q   <= link_d;
      for (int i = 0; i < LANES; i++) begin
        cnt_q[i]  <= cnt_d[i];
        copy_q[i] <= copy_d[i];
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.finish         = finish_q;
  assign bus.timedOut       = tout_q;
  assign bus.qualifiedLanes = qual_q;
  assign bus.rateId         = rate_q;
  assign bus.linkNumberOut  = link_q;
endmodule

// File: doc/rx_ts_qualifier.md
RX_TS_QUALIFIER -- requirements
Module: rx_ts_qualifier

Interface
REQ-001 SHALL have parameter LANES, default 16: number of lanes, 1..16.
REQ-002 SHALL have parameter OS_W, default 128: ordered-set width per lane in bits; symbol k = bits [8k+7:8k].
REQ-003 SHALL have parameter CNT_W, default 5: width of the per-lane consecutive counter.
REQ-004 SHALL have parameter TMR_W, default 24: width of the timeout counter.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse that begins or restarts qualification.
REQ-009 validOrderedSets  in  1  orderedSets valid this cycle.
REQ-010 orderedSets  in  LANES*OS_W  lane i at [i*OS_W+OS_W-1:i*OS_W].
REQ-011 laneActive  in  LANES  lanes participating.
REQ-012 expectTS2  in  1  0 = TS1 (symbol6 = 8'h4A), 1 = TS2 (symbol6 = 8'h45).
REQ-013 linkCheckEn  in  1  require symbol1 == expectLink.
REQ-014 expectLink  in  8  expected link number.
REQ-015 laneCheckEn  in  1  require symbol2 == lane index.
REQ-016 threshold  in  CNT_W  consecutive count needed; 0 is treated as 1.
REQ-017 requireAll  in  1  1 = all active lanes must qualify; 0 = any active lane.
REQ-018 timeoutCycles  in  TMR_W  timeout in clocks; 0 disables the timeout.
REQ-019 busy  out  1  high in COUNT.
REQ-020 finish  out  1  one-cycle success pulse.
REQ-021 timedOut  out  1  one-cycle timeout pulse.
REQ-022 qualifiedLanes  out  LANES  per-lane qualified flags.
REQ-023 rateId  out  8  symbol4 of the lowest qualified lane, captured at finish.
REQ-024 linkNumberOut  out  8  symbol1 of the same lane, captured at finish.

Function
REQ-025 SHALL implement states IDLE, COUNT, DONE and TOUT.
REQ-026 In IDLE or COUNT, start SHALL, on the next cycle, enter COUNT, clear all counters and qualifiedLanes, and load the timer with timeoutCycles.
REQ-027 A lane SHALL match when all of these hold: validOrderedSets, laneActive[i], symbol6 equals the expected identifier, the link check passes (or linkCheckEn=0), and the lane check passes (or laneCheckEn=0).
REQ-028 On a match whose symbols 1..5 equal the lane's stored copy, the counter SHALL increment, saturating at 2^CNT_W-1.
REQ-029 On a match whose symbols 1..5 differ, or the first match after clear, the counter SHALL load 1 and the stored copy SHALL update.
REQ-030 On a valid non-match, the counter SHALL clear to 0.
REQ-031 When validOrderedSets=0, counters SHALL hold.
REQ-032 qualifiedLanes[i] SHALL be registered (counter_next >= max(threshold,1)) AND laneActive[i], with one-cycle latency from the qualifying beat.
REQ-033 Completion condition: if requireAll=1, every laneActive lane is qualified and laneActive != 0; if requireAll=0, any lane is qualified.
REQ-034 In COUNT, the completion condition SHALL cause a transition to DONE; finish SHALL assert for that one DONE cycle, with rateId and linkNumberOut latched from the lowest-indexed qualified lane.
REQ-035 When timeoutCycles != 0, the timer SHALL decrement each COUNT cycle; on reaching 0 without completion, the block SHALL go to TOUT, and timedOut SHALL pulse for one cycle.
REQ-036 If completion and timer expiry occur in the same cycle, completion SHALL win.
REQ-037 DONE and TOUT SHALL return to IDLE after one cycle; qualifiedLanes, rateId and linkNumberOut SHALL hold until the next start.
REQ-038 Any start during COUNT SHALL restart per REQ-026, with no finish or timedOut pulse.
REQ-039 Changes to laneActive during COUNT SHALL clear the counters of deactivated lanes.

Reset
REQ-040 On reset, the block SHALL go to IDLE; busy, finish and timedOut SHALL be 0; qualifiedLanes, counters, stored copies, timer, rateId and linkNumberOut SHALL be 0.
REQ-041 Reset asserted mid-COUNT SHALL abort with no pulse.

Verification
REQ-042 LANES=4, laneActive=4'hF, TS1, threshold=8, requireAll=1, 8 identical TS1 per lane -> finish one cycle after beat 8; qualifiedLanes=4'hF; rateId = lane0 symbol4.
REQ-043 Lane 2 sends a differing TS1 at beat 5 -> lane-2 count restarts at 1; finish occurs 4 beats later than in REQ-042.
REQ-044 timeoutCycles=20, only 3 matching beats -> timedOut pulses at cycle 20 after start; finish stays 0.
REQ-045 requireAll=0, only lane 3 matches with linkCheckEn=1 and expectLink=8'h05 -> finish; qualifiedLanes=4'b1000; linkNumberOut=8'h05.
REQ-046 Completion on the same cycle as timer expiry -> finish=1, timedOut=0.
REQ-047 start re-pulsed after 4 beats, or reset mid-count -> counters cleared, no pulse, full threshold required again.
